// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encodings, port-owner codes
// and the timeout counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

    // Wide enough for the largest allowed TIMEOUT (255).
    localparam int unsigned CntW = 8;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter for an in-flight bus transaction; hit flags count == Limit.
module bus_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned Width = CntW,
    parameter int unsigned Limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit = (cnt_q == Width'(Limit));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction at a time,
// with alternating priority on ties and a timeout that aborts stuck transactions.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iGnt,
    output logic              iAck,
    output logic [DATA_W-1:0] iRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    input  logic [3:0]        dWstrb,
    output logic              dGnt,
    output logic              dAck,
    output logic [DATA_W-1:0] dRdata,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [3:0]        memWstrb,
    input  logic              memGnt,
    input  logic              memRvalid,
    input  logic [DATA_W-1:0] memRdata,
    output logic              busErr
);

    arb_state_e        state_q, state_d;
    owner_e            last_q, last_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              iack_q, iack_d;
    logic              dack_q, dack_d;
    logic              berr_q, berr_d;
    logic              ctr_clear, ctr_en, ctr_hit;
    logic              idle, i_win, d_win, abort;

    // On a tie the port that was not granted last wins.
    assign idle  = (state_q == StIdle) && !rst;
    assign i_win = iReq && (!dReq || (last_q == OwnD));
    assign d_win = dReq && (!iReq || (last_q == OwnI));
    assign iGnt  = idle && i_win;
    assign dGnt  = idle && d_win;

    assign ctr_en = (state_q != StIdle);

    bus_timeout_ctr #(
        .Width(CntW),
        .Limit(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clear),
        .enable(ctr_en),
        .hit   (ctr_hit)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        iack_d    = 1'b0;
        dack_d    = 1'b0;
        berr_d    = 1'b0;
        ctr_clear = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dGnt) begin
                    owner_d   = OwnD;
                    last_d    = OwnD;
                    addr_d    = dAddr;
                    we_d      = dWe;
                    wdata_d   = dWe ? dWdata : '0;
                    wstrb_d   = dWe ? dWstrb : 4'h0;
                    state_d   = StIssue;
                    ctr_clear = 1'b1;
                end else if (iGnt) begin
                    owner_d   = OwnI;
                    last_d    = OwnI;
                    addr_d    = iAddr;
                    we_d      = 1'b0;
                    wdata_d   = '0;
                    wstrb_d   = 4'h0;
                    state_d   = StIssue;
                    ctr_clear = 1'b1;
                end
            end
            StIssue: begin
                // An accepted command wins over a simultaneous timeout.
                if (memGnt) begin
                    if (we_q) begin
                        dack_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d   = StWait;
                        ctr_clear = 1'b1;
                    end
                end else if (ctr_hit) begin
                    abort = 1'b1;
                end
            end
            StWait: begin
                if (memRvalid) begin
                    if (owner_q == OwnD) begin
                        drdata_d = memRdata;
                        dack_d   = 1'b1;
                    end else begin
                        irdata_d = memRdata;
                        iack_d   = 1'b1;
                    end
                    state_d = StIdle;
                end else if (ctr_hit) begin
                    abort = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            berr_d  = 1'b1;
            state_d = StIdle;
            if (owner_q == OwnD) begin
                drdata_d = '0;
                dack_d   = 1'b1;
            end else begin
                irdata_d = '0;
                iack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= OwnI;
            owner_q  <= OwnI;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= 4'h0;
            irdata_q <= '0;
            drdata_q <= '0;
            iack_q   <= 1'b0;
            dack_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            iack_q   <= iack_d;
            dack_q   <= dack_d;
            berr_q   <= berr_d;
        end
    end

    assign memReq   = (state_q == StIssue);
    assign memWe    = memReq && we_q;
    assign memAddr  = memReq ? addr_q : '0;
    assign memWdata = memReq ? wdata_q : '0;
    assign memWstrb = memReq ? wstrb_q : 4'h0;

    assign iAck   = iack_q;
    assign dAck   = dack_q;
    assign iRdata = irdata_q;
    assign dRdata = drdata_q;
    assign busErr = berr_q;

endmodule
